// File: rtl/fsm_eg_pkg_amisha.sv
// Shared state encoding for the multi-channel a/b example FSM.
package fsm_eg_pkg_amisha;

   // Two-bit state code; 2'b11 is unreachable and recovers to S0.
   typedef enum logic [1:0] {
      S0   = 2'b00,
      S1   = 2'b01,
      S2   = 2'b10,
      SIll = 2'b11
   } state_t;

endpackage

// File: rtl/fsm_eg_ch_amisha.sv
// One channel of the a/b FSM: Moore y1, Mealy y0 (optionally registered),
// and a saturating counter of raw y0 pulses.
module fsm_eg_ch_amisha
   import fsm_eg_pkg_amisha::*;
#(
   parameter int unsigned CNT_W     = 8,
   parameter bit          REG_MEALY = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clear,
   input  logic             a,
   input  logic             b,
   output logic             y0,
   output logic             y1,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] cnt
);

   localparam logic [CNT_W-1:0] CntMax = '1;

   state_t           state_q, state_d;
   logic             raw_y0;
   logic             y0_q;
   logic [CNT_W-1:0] cnt_q;

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= S0;
      else       state_q <= state_d;
   end

   // Next state, Moore y1 and raw Mealy y0; a disabled channel holds state
   always_comb begin
      state_d = state_q;
      raw_y0  = 1'b0;
      y1      = 1'b0;
      case (state_q)
         S0: begin
            if (en && a) begin
               state_d = b ? S2 : S1;
               raw_y0  = b;
            end
         end
         S1: begin
            y1 = 1'b1;
            if (en && a) state_d = S0;
         end
         S2: begin
            y1 = 1'b1;
            if (en) state_d = S0;
         end
         default: state_d = S0;
      endcase
      // Mealy output stays quiet for the whole reset window
      if (reset) raw_y0 = 1'b0;
   end

   // One-cycle delayed copy of raw y0 for registered-Mealy mode
   always_ff @(posedge clk) begin
      if (reset) y0_q <= 1'b0;
      else       y0_q <= raw_y0;
   end

   // Saturating pulse counter; clear beats a coincident pulse
   always_ff @(posedge clk) begin
      if (reset)                             cnt_q <= '0;
      else if (clear)                        cnt_q <= '0;
      else if (raw_y0 && (cnt_q != CntMax))  cnt_q <= cnt_q + CNT_W'(1);
   end

   assign y0    = REG_MEALY ? y0_q : raw_y0;
   assign state = state_q;
   assign cnt   = cnt_q;

endmodule

// File: rtl/fsm_eg_multi_ch_amisha.sv
// NUM_CH independent a/b FSM channels with packed output buses.
module fsm_eg_multi_ch_amisha
   import fsm_eg_pkg_amisha::*;
#(
   parameter int unsigned NUM_CH    = 4,
   parameter int unsigned CNT_W     = 8,
   parameter int unsigned REG_MEALY = 0
) (
   input  logic                    clk_amisha,
   input  logic                    reset_amisha,
   input  logic [NUM_CH-1:0]       en_amisha,
   input  logic                    clear_amisha,
   input  logic [NUM_CH-1:0]       a_amisha,
   input  logic [NUM_CH-1:0]       b_amisha,
   output logic [NUM_CH-1:0]       y0_amisha,
   output logic [NUM_CH-1:0]       y1_amisha,
   output logic [2*NUM_CH-1:0]     state_amisha,
   output logic [CNT_W*NUM_CH-1:0] cnt_amisha,
   output logic                    any_y0_amisha
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      fsm_eg_ch_amisha #(
         .CNT_W     (CNT_W),
         .REG_MEALY (REG_MEALY != 0)
      ) u_ch (
         .clk   (clk_amisha),
         .reset (reset_amisha),
         .en    (en_amisha[i]),
         .clear (clear_amisha),
         .a     (a_amisha[i]),
         .b     (b_amisha[i]),
         .y0    (y0_amisha[i]),
         .y1    (y1_amisha[i]),
         .state (state_amisha[2*i +: 2]),
         .cnt   (cnt_amisha[CNT_W*i +: CNT_W])
      );
   end

   assign any_y0_amisha = |y0_amisha;

endmodule

// File: tb/tb_fsm_eg_multi_ch_amisha.sv
// Bench: three configurations driven in lockstep (comb y0, registered y0,
// 3-bit counters) against a per-channel behavioural model.
module tb_fsm_eg_multi_ch_amisha;

   logic       clk = 1'b0;
   logic       rst;
   logic       clr;
   logic [3:0] en, a, b;

   logic [3:0]  y0_c, y1_c, y0_r, y1_r, y0_s, y1_s;
   logic [7:0]  st_c, st_r, st_s;
   logic [31:0] cnt_c, cnt_r;
   logic [11:0] cnt_s;
   logic        any_c, any_r, any_s;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fsm_eg_multi_ch_amisha #(.NUM_CH(4), .CNT_W(8), .REG_MEALY(0)) dut_c (
      .clk_amisha(clk), .reset_amisha(rst), .en_amisha(en), .clear_amisha(clr),
      .a_amisha(a), .b_amisha(b), .y0_amisha(y0_c), .y1_amisha(y1_c),
      .state_amisha(st_c), .cnt_amisha(cnt_c), .any_y0_amisha(any_c));

   fsm_eg_multi_ch_amisha #(.NUM_CH(4), .CNT_W(8), .REG_MEALY(1)) dut_r (
      .clk_amisha(clk), .reset_amisha(rst), .en_amisha(en), .clear_amisha(clr),
      .a_amisha(a), .b_amisha(b), .y0_amisha(y0_r), .y1_amisha(y1_r),
      .state_amisha(st_r), .cnt_amisha(cnt_r), .any_y0_amisha(any_r));

   fsm_eg_multi_ch_amisha #(.NUM_CH(4), .CNT_W(3), .REG_MEALY(0)) dut_s (
      .clk_amisha(clk), .reset_amisha(rst), .en_amisha(en), .clear_amisha(clr),
      .a_amisha(a), .b_amisha(b), .y0_amisha(y0_s), .y1_amisha(y1_s),
      .state_amisha(st_s), .cnt_amisha(cnt_s), .any_y0_amisha(any_s));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_st [4];   // 0=S0, 1=S1, 2=S2
   int m_c8 [4];
   int m_c3 [4];
   bit m_rd [4];   // raw y0 from previous cycle
   bit model_ok = 1'b0;

   function automatic int nxt(input int s, input bit aa, input bit bb);
      if (s == 0) return (aa && bb) ? 2 : (aa ? 1 : 0);
      if (s == 1) return aa ? 0 : 1;
      return 0;
   endfunction

   function automatic bit raw(input int s, input bit aa, input bit bb, input bit ee,
                              input bit rr);
      return !rr && ee && (s == 0) && aa && bb;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         model_ok = 1'b1;
         for (int ch = 0; ch < 4; ch++) begin
            m_st[ch] = 0; m_c8[ch] = 0; m_c3[ch] = 0; m_rd[ch] = 1'b0;
         end
      end else if (model_ok) begin
         for (int ch = 0; ch < 4; ch++) begin
            bit r;
            r = raw(m_st[ch], a[ch], b[ch], en[ch], rst);
            m_rd[ch] = r;
            if (clr) begin
               m_c8[ch] = 0; m_c3[ch] = 0;
            end else if (r) begin
               if (m_c8[ch] < 255) m_c8[ch] = m_c8[ch] + 1;
               if (m_c3[ch] < 7)   m_c3[ch] = m_c3[ch] + 1;
            end
            if (en[ch]) m_st[ch] = nxt(m_st[ch], a[ch], b[ch]);
         end
      end
   end

   logic [3:0]  e_raw, e_dly, e_y1;
   logic [7:0]  e_st;
   logic [31:0] e_c8;
   logic [11:0] e_c3;

   // Every-cycle comparison of all three configurations against the model
   always @(negedge clk) begin
      if (model_ok) begin
         for (int ch = 0; ch < 4; ch++) begin
            e_raw[ch]         = raw(m_st[ch], a[ch], b[ch], en[ch], rst);
            e_dly[ch]         = m_rd[ch];
            e_y1[ch]          = (m_st[ch] != 0);
            e_st[2*ch +: 2]   = 2'(m_st[ch]);
            e_c8[8*ch +: 8]   = 8'(m_c8[ch]);
            e_c3[3*ch +: 3]   = 3'(m_c3[ch]);
         end
         chk("c_y0", y0_c, e_raw);   chk("r_y0", y0_r, e_dly);   chk("s_y0", y0_s, e_raw);
         chk("c_y1", y1_c, e_y1);    chk("r_y1", y1_r, e_y1);    chk("s_y1", y1_s, e_y1);
         chk("c_st", st_c, e_st);    chk("r_st", st_r, e_st);    chk("s_st", st_s, e_st);
         chk("c_cnt", cnt_c, e_c8);  chk("r_cnt", cnt_r, e_c8);  chk("s_cnt", cnt_s, e_c3);
         chk("c_any", any_c, |e_raw); chk("r_any", any_r, |e_dly); chk("s_any", any_s, |e_raw);
      end
   end

   // Apply inputs just after a rising edge, then return at the falling edge
   task automatic drive(input logic r, input logic [3:0] e, input logic c,
                        input logic [3:0] aa, input logic [3:0] bb);
      @(posedge clk);
      #1;
      rst = r; en = e; clr = c; a = aa; b = bb;
      @(negedge clk);
   endtask

   // ---------------- directed stimulus with literal expectations ----------------
   initial begin
      rst = 1'b1; clr = 1'b0; en = 4'hF;
      a = 4'($urandom); b = 4'($urandom);

      // Reset held two cycles
      drive(1, 4'hF, 0, 4'($urandom), 4'($urandom));
      drive(1, 4'hF, 0, 4'hF, 4'hF);
      chk("lit_rst_st", st_c, 8'h00);
      chk("lit_rst_y0", y0_c, 4'h0);
      chk("lit_rst_y1", y1_c, 4'h0);
      chk("lit_rst_cnt", cnt_c, 32'h0);

      // Release with a = 0
      drive(0, 4'hF, 0, 4'h0, 4'h0);
      drive(0, 4'hF, 0, 4'h0, 4'h0);        // ab=00 on ch0
      chk("lit_rel_st", st_c, 8'h00);
      drive(0, 4'hF, 0, 4'h1, 4'h0);        // ab=10
      drive(0, 4'hF, 0, 4'h1, 4'h1);        // ab=11 while in S1
      chk("lit_s1_st", st_c[1:0], 2'b01);
      chk("lit_s1_y1", y1_c[0], 1'b1);
      chk("lit_s1_y0", y0_c[0], 1'b0);
      drive(0, 4'hF, 0, 4'h0, 4'h1);        // ab=01
      chk("lit_back_s0", st_c[1:0], 2'b00);
      drive(0, 4'hF, 0, 4'h1, 4'h1);        // ab=11 from S0
      chk("lit_c_y0_now", y0_c[0], 1'b1);
      chk("lit_r_y0_now", y0_r[0], 1'b0);
      drive(0, 4'hF, 0, 4'h0, 4'h0);
      chk("lit_s2_st", st_c[1:0], 2'b10);
      chk("lit_s2_y1", y1_c[0], 1'b1);
      chk("lit_r_y0_late", y0_r[0], 1'b1);
      chk("lit_c_cnt1", cnt_c[7:0], 8'd1);
      chk("lit_r_cnt1", cnt_r[7:0], 8'd1);
      drive(0, 4'hF, 0, 4'h0, 4'h0);
      chk("lit_s2_exit", st_c[1:0], 2'b00);

      // Enable mask and channel independence
      drive(0, 4'b0101, 0, 4'hF, 4'hF);
      chk("lit_en_y0", y0_c, 4'b0101);
      chk("lit_en_any", any_c, 1'b1);
      drive(0, 4'hF, 0, 4'h0, 4'h0);
      chk("lit_en_st", st_c, 8'h22);
      chk("lit_en_r_y0", y0_r, 4'b0101);
      drive(0, 4'hF, 0, 4'h0, 4'h0);

      // Nine pulses on channel 1: 3-bit counter saturates at 7
      for (int k = 0; k < 9; k++) begin
         drive(0, 4'hF, 0, 4'b0010, 4'b0010);
         drive(0, 4'hF, 0, 4'h0, 4'h0);
      end
      chk("lit_sat7", cnt_s[5:3], 3'd7);
      chk("lit_cnt9", cnt_c[15:8], 8'd9);
      // Clear coincident with a pulse wins
      drive(0, 4'hF, 1, 4'b0010, 4'b0010);
      chk("lit_clr_y0", y0_s[1], 1'b1);
      drive(0, 4'hF, 0, 4'h0, 4'h0);
      chk("lit_clr_s", cnt_s, 12'h0);
      chk("lit_clr_c", cnt_c, 32'h0);

      // Reset while ch0 in S1 and ch2 in S2
      drive(0, 4'hF, 0, 4'b0101, 4'b0100);
      drive(1, 4'hF, 0, 4'hF, 4'hF);
      chk("lit_mid_st", st_c, 8'h21);
      chk("lit_mid_y0", y0_c, 4'h0);
      drive(1, 4'hF, 0, 4'h0, 4'h0);
      chk("lit_mid_rst_st", st_c, 8'h00);
      chk("lit_mid_rst_cnt", cnt_c, 32'h0);
      chk("lit_mid_rst_ry0", y0_r, 4'h0);
      drive(0, 4'hF, 0, 4'h0, 4'h0);
      drive(0, 4'hF, 0, 4'hF, 4'hF);
      drive(0, 4'hF, 0, 4'h0, 4'h0);
      drive(0, 4'hF, 0, 4'h0, 4'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fsm_eg_multi_ch_amisha.md
# fsm_eg_multi_ch_amisha

Parametrised, multi-channel successor to the two-input (a/b) multi-segment example FSM. It instantiates NUM_CH independent copies of the a/b state machine, each with a Moore output y1 and a Mealy output y0. Each channel adds a per-channel enable, an optional registered-Mealy mode and a saturating y0 event counter. It sits in the FSM example set as the reusable, scalable version of the single-channel block.

## Interface
- NUM_CH, default 4: number of independent channels (1..16).
- CNT_W, default 8: width of each per-channel y0 event counter.
- REG_MEALY, default 0: 0 = y0 combinational (same cycle); 1 = y0 registered (one cycle later).
- clk_amisha  in  1  single clock; all state changes on its rising edge.
- reset_amisha  in  1  synchronous, active-high reset.
- en_amisha  in  NUM_CH  per-channel enable; a low bit freezes that channel's state and suppresses its y0.
- clear_amisha  in  1  synchronous clear of all counters; FSM state is untouched.
- a_amisha  in  NUM_CH  per-channel input a.
- b_amisha  in  NUM_CH  per-channel input b.
- y0_amisha  out  NUM_CH  per-channel Mealy output.
- y1_amisha  out  NUM_CH  per-channel Moore output.
- state_amisha  out  2*NUM_CH  per-channel state code; channel i occupies bits [2i+1:2i].
- cnt_amisha  out  CNT_W*NUM_CH  per-channel y0 count; channel i occupies bits [CNT_W*(i+1)-1:CNT_W*i].
- any_y0_amisha  out  1  OR of all y0_amisha bits.

## Operation
- State codes: S0 = 2'b00, S1 = 2'b01, S2 = 2'b10. Code 2'b11 is illegal; it gives y0 = 0 and y1 = 0 and always moves to S0 on the next edge.
- Transitions per channel when en = 1:
  - S0, a = 1 and b = 1: go to S2; raw y0 = 1.
  - S0, a = 1 and b = 0: go to S1.
  - S0, a = 0: stay in S0.
  - S1, a = 1: go to S0. S1, a = 0: stay in S1.
  - S2: always go to S0.
- Moore output: y1 = 1 in S1 and S2; y1 = 0 in S0.
- Raw Mealy output: y0 = 1 only in S0 with a = 1, b = 1 and en = 1. It is 0 in every other case, including while reset_amisha = 1.
- When en = 0: the channel's state holds, raw y0 = 0, and y1 still reflects the held state.
- REG_MEALY = 0: y0_amisha equals raw y0.
- REG_MEALY = 1: y0_amisha is raw y0 delayed by one flop.
- Counter: increments by 1 on each edge where raw y0 = 1. It saturates at 2^CNT_W - 1 and holds there.
- Counter priority: reset, then clear, then increment. A clear in the same cycle as a y0 pulse leaves the counter at 0, not 1.
- Channels are fully independent. Any combination of channels may pulse y0 in the same cycle.

## Timing
- Reset is sampled on the rising edge and overrides everything, including a reset asserted mid-transition. The edge after reset is asserted gives:
  - all states S0, so y1 = 0;
  - all counters 0;
  - registered y0 = 0.
- Combinational y0 is 0 for the whole time reset is high.
- First transition: on the first edge with reset_amisha = 0.
- y1 changes one cycle after the input edge that causes the transition.
- y0 latency:
  - REG_MEALY = 0: same cycle as the a/b condition (0 cycles).
  - REG_MEALY = 1: exactly one cycle after that condition.
- Counter latency: the count is visible one cycle after the raw y0 pulse, for both modes.
- Saturation boundary: at 2^CNT_W - 1 a further pulse leaves the count unchanged; y0 still pulses.

## Structure
- Package fsm_eg_pkg_amisha holds:
  - the state code localparams S0, S1, S2;
  - a state typedef, 2 bits wide.
- Sub-module fsm_eg_ch_amisha: one channel, containing the state register, next-state logic, Moore/Mealy output logic, the optional y0 flop and the saturating counter.
- The top level contains:
  - a generate loop over NUM_CH channel instances;
  - the bus packing;
  - the any_y0 OR reduction.
- Target size: roughly 80 lines for the sub-module and 80 lines for the top level.

## Test plan
- Reset check: hold reset 2 cycles with random a/b. Required: all states 00, y0 = 0, y1 = 0, counts 0. Release reset with a = 0. Required: all channels stay in S0.
- Main path, NUM_CH = 4, REG_MEALY = 0, channel 0: apply a/b = 00, 10, 11, 01 on successive cycles. Required:
  - states S0, S1, S0, S0;
  - y1 = 0, 1, 0, 0;
  - y0 never 1, because a = 1 in S1 returns to S0.
  - Then apply 11 from S0. Required: y0 = 1 in that same cycle; next state S2 with y1 = 1; then S0; count = 1.
- Registered mode, REG_MEALY = 1: repeat the 11 from S0. Required: y0 rises exactly one cycle later than in REG_MEALY = 0; the count still equals 1 one cycle after the condition.
- Enable and independence: en = 4'b0101 with a = b = 4'b1111 in S0. Required: y0 = 4'b0101; channels 1 and 3 hold S0; any_y0 = 1.
- Saturation and clear, CNT_W = 3: give 9 y0 pulses. Required: count saturates at 7. Then assert clear in the same cycle as a y0 pulse. Required: count = 0.
- Reset mid-operation: assert reset while a channel is in S2 and another is in S1. Required: both are in S0 on the next edge, counts are 0, and no y0 pulses during reset.
